// File: rtl/pipelined_acc_adder.sv
// One-stage registered adder with plain-add and accumulate modes, sitting between
// a valid/ready producer and consumer with full backpressure and no bubbles.
module pipelined_acc_adder #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter bit SAT   = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  if (ACC_W < WIDTH + 2) begin : g_bad_acc_w
    $error("pipelined_acc_adder: ACC_W must be >= WIDTH+2");
  end

  localparam int PAD_OP  = ACC_W - WIDTH;
  localparam int PAD_SUM = ACC_W - WIDTH - 1;

  logic             in_fire;
  logic             out_fire;
  logic [WIDTH:0]   plain_sum;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] result;
  logic             result_ovf;

  // Handshake: a transfer happens on a rising edge where valid && ready on that
  // side. in_ready depends only on the output register and the consumer, so the
  // stage accepts new operands whenever its held result is empty or leaving now.
  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    plain_sum = {1'b0, in_a} + {1'b0, in_b};
    acc_base  = acc_clr ? '0 : acc_q;
    acc_sum   = {1'b0, acc_base}
              + {1'b0, {PAD_OP{1'b0}}, in_a}
              + {1'b0, {PAD_OP{1'b0}}, in_b};
    acc_ovf   = acc_sum[ACC_W];
    // Wrap keeps the low bits; saturate pins at all-ones and stays there.
    if (acc_ovf && SAT) acc_next = '1;
    else                acc_next = acc_sum[ACC_W-1:0];
    if (in_mode) begin
      result     = acc_next;
      result_ovf = acc_ovf;
    end else begin
      result     = {{PAD_SUM{1'b0}}, plain_sum};
      result_ovf = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_sum   <= result;
        out_ovf   <= result_ovf;
        out_cnt   <= out_cnt + CNT_W'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // A clear alongside an accepted accumulate is already folded into acc_base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (in_fire && in_mode) begin
      acc_q <= acc_next;
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

endmodule

// File: tb/tb_pipelined_acc_adder.sv
// Directed scoreboard bench: a wrap instance and a saturate instance share stimulus,
// each with its own expected-result queue checked by a monitor on the falling edge.
module tb_pipelined_acc_adder;
  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;
  localparam int EW    = 1 + CNT_W + ACC_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic acc_clr = 1'b0;
  logic out_ready = 1'b0;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;

  logic in_ready0, in_ready1, out_valid0, out_valid1, out_ovf0, out_ovf1;
  logic [ACC_W-1:0] out_sum0, out_sum1;
  logic [CNT_W-1:0] out_cnt0, out_cnt1;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp0_q[$];
  logic [EW-1:0] exp1_q[$];

  always #5 clk = ~clk;

  pipelined_acc_adder #(.WIDTH(WIDTH), .ACC_W(ACC_W), .SAT(1'b0), .CNT_W(CNT_W)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .acc_clr(acc_clr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
    .out_ovf(out_ovf0), .out_cnt(out_cnt0)
  );

  pipelined_acc_adder #(.WIDTH(WIDTH), .ACC_W(ACC_W), .SAT(1'b1), .CNT_W(CNT_W)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .acc_clr(acc_clr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
    .out_ovf(out_ovf1), .out_cnt(out_cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pop one expectation per output transfer on each instance.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid0 && out_ready) begin
        if (exp0_q.size() == 0) check("wrap_unexpected_out", out_valid0, 0);
        else begin
          e = exp0_q.pop_front();
          check("wrap_sum", out_sum0, e[ACC_W-1:0]);
          check("wrap_cnt", out_cnt0, e[ACC_W+CNT_W-1:ACC_W]);
          check("wrap_ovf", out_ovf0, e[EW-1]);
        end
      end
      if (rst_n && out_valid1 && out_ready) begin
        if (exp1_q.size() == 0) check("sat_unexpected_out", out_valid1, 0);
        else begin
          e = exp1_q.pop_front();
          check("sat_sum", out_sum1, e[ACC_W-1:0]);
          check("sat_cnt", out_cnt1, e[ACC_W+CNT_W-1:ACC_W]);
          check("sat_ovf", out_ovf1, e[EW-1]);
        end
      end
    end
  end

  // Present one transfer and hold it until accepted; leaves in_valid high so
  // back-to-back calls stream without gaps. Returns at accept edge + 1.
  task automatic xfer(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic mode, input logic clr,
                      input logic [ACC_W-1:0] s0, input logic o0,
                      input logic [ACC_W-1:0] s1, input logic o1,
                      input logic [CNT_W-1:0] cnt, output int waits);
    exp0_q.push_back({o0, cnt, s0});
    exp1_q.push_back({o1, cnt, s1});
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_mode = mode;
    acc_clr = clr;
    waits = 0;
    @(negedge clk);
    while (!in_ready0 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready0) begin
      check("xfer_accept_timeout", in_ready0, 1);
      in_valid = 1'b0;
      acc_clr = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      acc_clr = 1'b0;
      check("latency_wrap", out_valid0, 1);
      check("latency_sat", out_valid1, 1);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    acc_clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    logic [ACC_W-1:0] s;
    #2;
    check("rst_out_valid", out_valid0, 0);
    check("rst_out_sum", out_sum0, 0);
    check("rst_out_ovf", out_ovf1, 0);
    check("rst_out_cnt", out_cnt1, 0);
    check("rst_in_ready", in_ready0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Plain add
    xfer(4'd5, 4'd5, 1'b0, 1'b0, 8'd10, 1'b0, 8'd10, 1'b0, 8'd1, w);
    xfer(4'd15, 4'd15, 1'b0, 1'b0, 8'd30, 1'b0, 8'd30, 1'b0, 8'd2, w);
    idle(1);

    // Back-to-back accumulate up to overflow: 30,60..240 then 270
    for (int k = 1; k <= 8; k++) begin
      s = 8'(30 * k);
      xfer(4'd15, 4'd15, 1'b1, 1'b0, s, 1'b0, s, 1'b0, 8'(2 + k), w);
      check("stream_stall", w, 0);
    end
    xfer(4'd15, 4'd15, 1'b1, 1'b0, 8'd14, 1'b1, 8'd255, 1'b1, 8'd11, w);
    check("stream_stall_ovf", w, 0);
    xfer(4'd1, 4'd0, 1'b1, 1'b0, 8'd15, 1'b0, 8'd255, 1'b1, 8'd12, w);
    check("stream_stall_post", w, 0);

    // Clear-then-add, then build the accumulator to 100
    xfer(4'd15, 4'd15, 1'b1, 1'b1, 8'd30, 1'b0, 8'd30, 1'b0, 8'd13, w);
    xfer(4'd15, 4'd15, 1'b1, 1'b0, 8'd60, 1'b0, 8'd60, 1'b0, 8'd14, w);
    xfer(4'd15, 4'd15, 1'b1, 1'b0, 8'd90, 1'b0, 8'd90, 1'b0, 8'd15, w);
    xfer(4'd5, 4'd5, 1'b1, 1'b0, 8'd100, 1'b0, 8'd100, 1'b0, 8'd16, w);
    xfer(4'd3, 4'd4, 1'b1, 1'b1, 8'd7, 1'b0, 8'd7, 1'b0, 8'd17, w);
    idle(1);
    check("drain_out_valid", out_valid0, 0);

    // Clear alone: no output, no count
    acc_clr = 1'b1;
    @(posedge clk);
    #1;
    acc_clr = 1'b0;
    check("clr_only_no_valid", out_valid0, 0);
    check("clr_only_cnt", out_cnt0, 17);
    idle(1);
    check("clr_only_no_valid_late", out_valid1, 0);
    xfer(4'd1, 4'd1, 1'b1, 1'b0, 8'd2, 1'b0, 8'd2, 1'b0, 8'd18, w);
    idle(1);

    // Backpressure: result 10 held while 3+4 waits
    out_ready = 1'b0;
    xfer(4'd5, 4'd5, 1'b0, 1'b0, 8'd10, 1'b0, 8'd10, 1'b0, 8'd19, w);
    exp0_q.push_back({1'b0, 8'd20, 8'd7});
    exp1_q.push_back({1'b0, 8'd20, 8'd7});
    in_a = 4'd3;
    in_b = 4'd4;
    in_mode = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready0, 0);
      check("bp_sum_stable", out_sum0, 10);
      check("bp_valid_held", out_valid1, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_release", in_ready1, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_new_sum", out_sum0, 7);
    check("bp_cnt_once", out_cnt0, 20);
    idle(1);

    // Asynchronous reset while a result is held
    xfer(4'd15, 4'd15, 1'b1, 1'b1, 8'd30, 1'b0, 8'd30, 1'b0, 8'd21, w);
    xfer(4'd10, 4'd10, 1'b1, 1'b0, 8'd50, 1'b0, 8'd50, 1'b0, 8'd22, w);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pre_rst_sum", out_sum0, 50);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid0, 0);
    check("async_rst_sum", out_sum0, 0);
    check("async_rst_sum_sat", out_sum1, 0);
    check("async_rst_cnt", out_cnt0, 0);
    check("async_rst_in_ready", in_ready0, 1);
    exp0_q.delete();
    exp1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    xfer(4'd3, 4'd4, 1'b1, 1'b0, 8'd7, 1'b0, 8'd7, 1'b0, 8'd1, w);
    idle(3);

    check("wrap_queue_empty", exp0_q.size(), 0);
    check("sat_queue_empty", exp1_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
